// File: rtl/sram_sp_pkg.sv
// Shared types and helpers for the single-port scratchpad SRAM.
package sram_sp_pkg;

  localparam int unsigned SRAM_DEFAULT_MEM_AW = 10;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_init_state_t;

  function automatic int unsigned sram_sw(input int unsigned xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/sram_sp_mem_if.sv
// Generic RAM port bundle between the AHB3 bridge (master) and the SRAM (slave).
interface sram_sp_mem_if
  import sram_sp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned WORD_AW = 30
) ();

  localparam int unsigned SW = sram_sw(XLEN);

  logic               sram_ce;
  logic               sram_we;
  logic [WORD_AW-1:0] sram_waddr;
  logic [XLEN-1:0]    sram_din;
  logic [SW-1:0]      sram_sel;
  logic [XLEN-1:0]    sram_dout;

  modport master (
    output sram_ce, sram_we, sram_waddr, sram_din, sram_sel,
    input  sram_dout
  );

  modport slave (
    input  sram_ce, sram_we, sram_waddr, sram_din, sram_sel,
    output sram_dout
  );

endinterface

// File: rtl/sram_sp_array.sv
// Pure storage: per-lane write enables, registered read, no reset on contents.
// Kept standalone so a technology macro can drop in here.
module sram_sp_array
  import sram_sp_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MEM_AW = SRAM_DEFAULT_MEM_AW
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic                    re,
  input  logic [MEM_AW-1:0]       addr,
  input  logic [XLEN-1:0]         din,
  input  logic [sram_sw(XLEN)-1:0] be,
  output logic [XLEN-1:0]         rdata
);

  localparam int unsigned DEPTH = 32'(1) << MEM_AW;
  localparam int unsigned SW    = sram_sw(XLEN);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < SW; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_sp_mem.sv
// Single-port scratchpad SRAM: post-reset clear sweep, range check and
// muxing between the sweep and the bridge port in front of the storage array.
module sram_sp_mem
  import sram_sp_pkg::*;
#(
  parameter int unsigned    XLEN        = 32,
  parameter int unsigned    WORD_AW     = 30,
  parameter int unsigned    MEM_AW      = SRAM_DEFAULT_MEM_AW,
  parameter bit             INIT_ENABLE = 1'b1,
  parameter logic [XLEN-1:0] INIT_VALUE = '0
) (
  input  logic            ahb3_clk_i,
  input  logic            ahb3_rst_ni,
  sram_sp_mem_if.slave    mem_if,
  output logic            init_done_o,
  output logic            oor_o
);

  localparam int unsigned DEPTH = 32'(1) << MEM_AW;
  localparam int unsigned SW    = sram_sw(XLEN);
  localparam int unsigned CW    = MEM_AW + 1;

  sram_init_state_t state_q;
  logic [CW-1:0]    cnt_q;
  logic             dout_vld_q;

  logic              in_range_c;
  logic              sweep_c;
  logic              access_c;
  logic              arr_we_c;
  logic              arr_re_c;
  logic [MEM_AW-1:0] arr_addr_c;
  logic [XLEN-1:0]   arr_din_c;
  logic [SW-1:0]     arr_be_c;
  logic [XLEN-1:0]   arr_rdata;

  // Upper word-address bits beyond the implemented depth must be zero.
  if (WORD_AW > MEM_AW) begin : g_range
    assign in_range_c = ~|mem_if.sram_waddr[WORD_AW-1:MEM_AW];
  end else begin : g_full
    assign in_range_c = 1'b1;
  end

  always_comb begin
    sweep_c    = (state_q == INIT) && INIT_ENABLE;
    access_c   = (state_q == RUN) && mem_if.sram_ce && in_range_c;
    arr_we_c   = sweep_c || (access_c && mem_if.sram_we);
    arr_re_c   = access_c && !mem_if.sram_we;
    arr_addr_c = sweep_c ? cnt_q[MEM_AW-1:0] : mem_if.sram_waddr[MEM_AW-1:0];
    arr_din_c  = sweep_c ? INIT_VALUE : mem_if.sram_din;
    arr_be_c   = sweep_c ? {SW{1'b1}} : mem_if.sram_sel;
  end

  sram_sp_array #(
    .XLEN   (XLEN),
    .MEM_AW (MEM_AW)
  ) u_array (
    .clk   (ahb3_clk_i),
    .we    (arr_we_c),
    .re    (arr_re_c),
    .addr  (arr_addr_c),
    .din   (arr_din_c),
    .be    (arr_be_c),
    .rdata (arr_rdata)
  );

  // Sweep/run control; dout_vld_q masks the unreset array output to 0
  // until a valid in-range read, and after an out-of-range read.
  always_ff @(posedge ahb3_clk_i or negedge ahb3_rst_ni) begin
    if (!ahb3_rst_ni) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_o <= 1'b0;
      oor_o       <= 1'b0;
      dout_vld_q  <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          oor_o <= 1'b0;
          if (INIT_ENABLE) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DEPTH - 1)) begin
              state_q     <= RUN;
              init_done_o <= 1'b1;
            end
          end else begin
            state_q     <= RUN;
            init_done_o <= 1'b1;
          end
        end
        RUN: begin
          oor_o <= mem_if.sram_ce && !in_range_c;
          if (mem_if.sram_ce && !mem_if.sram_we) dout_vld_q <= in_range_c;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign mem_if.sram_dout = dout_vld_q ? arr_rdata : '0;

endmodule

// File: tb/tb_sram_sp_mem.sv
// Directed bench for sram_sp_mem: sweep instance (A) and no-sweep instance (B).
module tb_sram_sp_mem;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic done_a, done_b, oor_a, oor_b;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_dout[2];

  always #5 clk = ~clk;

  sram_sp_mem_if #(.XLEN(32), .WORD_AW(8)) ifa ();
  sram_sp_mem_if #(.XLEN(32), .WORD_AW(8)) ifb ();

  sram_sp_mem #(
    .XLEN(32), .WORD_AW(8), .MEM_AW(4),
    .INIT_ENABLE(1'b1), .INIT_VALUE(32'hDEADBEEF)
  ) dut_a (
    .ahb3_clk_i(clk), .ahb3_rst_ni(rst_a), .mem_if(ifa.slave),
    .init_done_o(done_a), .oor_o(oor_a)
  );

  sram_sp_mem #(
    .XLEN(32), .WORD_AW(8), .MEM_AW(4),
    .INIT_ENABLE(1'b0), .INIT_VALUE(32'h0)
  ) dut_b (
    .ahb3_clk_i(clk), .ahb3_rst_ni(rst_b), .mem_if(ifb.slave),
    .init_done_o(done_b), .oor_o(oor_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input logic ce, input logic we, input logic [7:0] addr,
                       input logic [31:0] din, input logic [3:0] sel);
    if (b) begin
      ifb.sram_ce = ce; ifb.sram_we = we; ifb.sram_waddr = addr;
      ifb.sram_din = din; ifb.sram_sel = sel;
    end else begin
      ifa.sram_ce = ce; ifa.sram_we = we; ifa.sram_waddr = addr;
      ifa.sram_din = din; ifa.sram_sel = sel;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dout_of(input bit b);
    return b ? ifb.sram_dout : ifa.sram_dout;
  endfunction

  function automatic logic oor_of(input bit b);
    return b ? oor_b : oor_a;
  endfunction

  task automatic rd(input bit b, input logic [7:0] addr, input logic [31:0] exp, input logic exp_oor);
    drive(b, 1'b1, 1'b0, addr, 32'h0, 4'h0);
    exp_q.push_back(exp);
    step();
    drive(b, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    last_dout[b] = exp_q.pop_front();
    chk("rd_data", dout_of(b), last_dout[b]);
    chk("rd_oor", 32'(oor_of(b)), 32'(exp_oor));
  endtask

  task automatic wr(input bit b, input logic [7:0] addr, input logic [31:0] din,
                    input logic [3:0] sel, input logic exp_oor);
    drive(b, 1'b1, 1'b1, addr, din, sel);
    step();
    drive(b, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    chk("wr_hold", dout_of(b), last_dout[b]);
    chk("wr_oor", 32'(oor_of(b)), 32'(exp_oor));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    last_dout[0] = '0;
    last_dout[1] = '0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    #2;
    chk("rst_dout_a", ifa.sram_dout, 32'h0);
    chk("rst_done_a", 32'(done_a), 32'h0);
    chk("rst_oor_a", 32'(oor_a), 32'h0);
    chk("rst_done_b", 32'(done_b), 32'h0);

    // Release both resets mid-cycle; A is hammered with an out-of-range read during the sweep.
    step();
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'd16, 32'hFFFF_FFFF, 4'hF);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("sweep_done", 32'(done_a), 32'(i == 16));
      chk("sweep_dout", ifa.sram_dout, 32'h0);
      chk("sweep_oor", 32'(oor_a), 32'h0);
      if (i == 1) chk("noinit_done_b", 32'(done_b), 32'h1);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);

    for (int a = 0; a < 16; a++) rd(1'b0, 8'(a), 32'hDEADBEEF, 1'b0);

    // Byte lanes
    wr(1'b0, 8'd5, 32'h11223344, 4'hF, 1'b0);
    wr(1'b0, 8'd5, 32'hAABBCCDD, 4'b0101, 1'b0);
    rd(1'b0, 8'd5, 32'h11BB33DD, 1'b0);

    // Back-to-back write/read, then idle hold
    wr(1'b0, 8'd3, 32'h0000CAFE, 4'hF, 1'b0);
    rd(1'b0, 8'd3, 32'h0000CAFE, 1'b0);
    step();
    chk("idle_hold", ifa.sram_dout, 32'h0000CAFE);

    // Out of range
    wr(1'b0, 8'd16, 32'hFFFFFFFF, 4'hF, 1'b1);
    step();
    chk("oor_pulse_end", 32'(oor_a), 32'h0);
    rd(1'b0, 8'd0, 32'hDEADBEEF, 1'b0);
    rd(1'b0, 8'd16, 32'h0, 1'b1);
    wr(1'b0, 8'd7, 32'h55555555, 4'h0, 1'b0);
    rd(1'b0, 8'd7, 32'hDEADBEEF, 1'b0);

    // Reset from RUN, then again mid-sweep at counter 7
    rd(1'b0, 8'd5, 32'h11BB33DD, 1'b0);
    rst_a = 1'b0;
    #1;
    chk("async_rst_dout", ifa.sram_dout, 32'h0);
    chk("async_rst_done", 32'(done_a), 32'h0);
    rst_a = 1'b1;
    last_dout[0] = '0;
    for (int i = 1; i <= 7; i++) step();
    chk("mid_sweep_done", 32'(done_a), 32'h0);
    rst_a = 1'b0;
    #1;
    chk("mid_rst_dout", ifa.sram_dout, 32'h0);
    chk("mid_rst_done", 32'(done_a), 32'h0);
    rst_a = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("resweep_done", 32'(done_a), 32'(i == 16));
    end
    rd(1'b0, 8'd5, 32'hDEADBEEF, 1'b0);
    rd(1'b0, 8'd3, 32'hDEADBEEF, 1'b0);

    // No-sweep instance keeps contents across reset
    wr(1'b1, 8'd2, 32'h12345678, 4'hF, 1'b0);
    rd(1'b1, 8'd2, 32'h12345678, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("b_rst_dout", ifb.sram_dout, 32'h0);
    chk("b_rst_done", 32'(done_b), 32'h0);
    rst_b = 1'b1;
    last_dout[1] = '0;
    step();
    chk("b_done_edge1", 32'(done_b), 32'h1);
    rd(1'b1, 8'd2, 32'h12345678, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_sp_mem.md
# sram_sp_mem

Single-port synchronous SRAM that sits directly downstream of the AHB3-to-SRAM bridge and consumes its generic RAM port bundle (`sram_ce`, `sram_we`, `sram_waddr`, `sram_din`, `sram_sel`, `sram_dout`). It provides:
- byte-lane writes;
- a one-cycle registered read;
- a post-reset hardware initialisation sweep;
- out-of-range address detection.

It is the default on-chip scratchpad behind every SoC AHB3 SRAM slave.

## Interface
Parameters:
- `XLEN`, 32, data width; legal values 32, 16, 8.
- `WORD_AW`, 30, width of the incoming word address; matches the bridge's `PLEN - BYTE_AW`.
- `MEM_AW`, 10, implemented word-address bits; `DEPTH = 2**MEM_AW` words.
- `INIT_ENABLE`, 1, 1 = run the clear sweep after every reset.
- `INIT_VALUE`, 0, XLEN-bit word written during the sweep.
- `SW` (derived), `XLEN/8`, byte-select width.

Ports:
- `ahb3_clk_i`  in  1  clock; all state changes on rising edge.
- `ahb3_rst_ni`  in  1  reset; asynchronous, active-low.
- `sram_ce`  in  1  access enable.
- `sram_we`  in  1  1 = write, 0 = read (qualified by `sram_ce`).
- `sram_waddr`  in  WORD_AW  word address.
- `sram_din`  in  XLEN  write data.
- `sram_sel`  in  SW  byte-lane enables; bit i covers `din[8i+7:8i]`.
- `sram_dout`  out  XLEN  registered read data.
- `init_done_o`  out  1  high once the array is usable.
- `oor_o`  out  1  one-cycle pulse on an out-of-range access.

## Operation
- **Out-of-range:** an access is out of range when `sram_waddr[WORD_AW-1:MEM_AW]` is non-zero.
- **FSM states:** `INIT` and `RUN`.
  - Reset assertion forces `INIT`, clears the sweep counter, clears `init_done_o`, and zeroes `sram_dout`/`oor_o`.
  - Array contents are not reset.
- **INIT** (only when `INIT_ENABLE=1`):
  - Each cycle writes `INIT_VALUE` with all lanes to `counter`, then increments `counter` (MEM_AW+1 bits).
  - On the cycle that writes address `DEPTH-1`, the next state is `RUN`.
  - All `sram_*` inputs are ignored; `sram_dout` stays 0; `oor_o` stays 0.
- **`INIT_ENABLE=0`:** `INIT` lasts exactly one cycle with no writes, then goes to `RUN`.
- **RUN, write** (`ce=1, we=1`, in range): each byte lane with `sel[i]=1` is updated; other lanes are kept. `sram_dout` holds its previous value.
- **RUN, read** (`ce=1, we=0`, in range): `sram_dout` takes `mem[addr]` at the edge. It holds until the next read. `sram_sel` is ignored.
- **Out-of-range access:** writes are discarded; reads load 0 into `sram_dout`; `oor_o=1` for that one cycle.
- **`ce=0`:** no array change; `sram_dout` holds.
- **`sel=0` write:** legal no-op; no `oor_o` if in range.
- **Read after write, same address:** the read returns the newly written data. There is no bypass needed because accesses are strictly sequential on a single port.
- **Reset mid-sweep:** the sweep restarts from address 0 after release.

## Timing
- **Read latency:** 1 cycle. Address/`ce` sampled at edge N; data valid after edge N, usable in cycle N+1. This matches the bridge's expectation that `sram_dout` is valid when it asserts `hready` one cycle after issuing the address.
- **Write:** takes effect at the sampling edge.
- **Throughput:** one access per cycle, no back-pressure.
- **Init duration:** `init_done_o` rises after edge `DEPTH` following reset release, or after edge 1 when `INIT_ENABLE=0`. Accesses are valid from the edge where `init_done_o` is already 1.
- **Reset values:** `sram_dout=0`, `init_done_o=0`, `oor_o=0`.

## Structure
- **Shared package `sram_sp_pkg`:**
  - function `sram_sw(XLEN)` returning SW;
  - enum `sram_init_state_t {INIT, RUN}`;
  - constant `SRAM_DEFAULT_MEM_AW = 10`.
- **One sub-module `sram_sp_array`:** the pure storage array with per-lane write enables and registered read, no reset on the array. It is kept separate so technology macros can replace it.
- **Top level:** holds the FSM, sweep counter, address-range check, and write/read muxing between the sweep and the external ports.

## Test plan
- **Reset with `INIT_ENABLE=1`, `MEM_AW=4`, `INIT_VALUE=0xDEADBEEF`:** `init_done_o` rises after exactly 16 edges. A read of every address 0..15 returns `0xDEADBEEF`. `sram_dout=0` throughout `INIT`.
- **Byte lanes:** write `0x11223344` with `sel=4'hF` to addr 5, then `0xAABBCCDD` with `sel=4'b0101`. Read addr 5 -> `0x11BB33DD`, valid one cycle after the read address.
- **Back-to-back:** write addr 3 = `0x0000CAFE`, next cycle read addr 3 -> `0x0000CAFE`. A following idle cycle (`ce=0`) keeps `sram_dout` at `0x0000CAFE`.
- **Out of range:** with `MEM_AW=4`, write addr 16 = `0xFFFFFFFF` -> `oor_o` pulses 1 cycle and addr 0 is unchanged. Read addr 16 -> `sram_dout=0` and `oor_o` pulses.
- **Reset mid-sweep:** assert `ahb3_rst_ni=0` asynchronously at sweep address 7. Outputs go to 0 immediately. After release, the sweep takes a full 16 cycles again.
- **`INIT_ENABLE=0`:** `init_done_o=1` after the first edge post-reset. A previously written addr 2 keeps `0x12345678` across the reset.
